// File: rtl/serial_adder_param.sv
// Bit-serial adder/subtractor: WIDTH-bit operands in MSB first, WIDTH+1-bit
// result out MSB first, framed by en_o. busy_o covers the whole transaction.
module serial_adder_param #(
    parameter int WIDTH  = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic sub_i,
    input  logic ina,
    input  logic inb,
    output logic out,
    output logic en_o,
    output logic busy_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, SEND} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
    logic [WIDTH:0]   r_res, w_res_nxt;
    logic [WIDTH:0]   w_ext_a, w_ext_b, w_sum;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_sub, w_sub_nxt;
    logic             r_last, w_last_nxt;
    logic             r_out, w_out_nxt;
    logic             r_en_o, w_en_o_nxt;
    logic             r_busy, w_busy_nxt;

    // One extra bit of headroom means neither add nor subtract can overflow.
    assign w_ext_a = SIGNED ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
    assign w_ext_b = SIGNED ? {r_b[WIDTH-1], r_b} : {1'b0, r_b};
    assign w_sum   = w_ext_a + (r_sub ? ~w_ext_b : w_ext_b) + {{WIDTH{1'b0}}, r_sub};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_sub   <= 1'b0;
            r_last  <= 1'b0;
            r_out   <= 1'b0;
            r_en_o  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_res   <= w_res_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sub   <= w_sub_nxt;
            r_last  <= w_last_nxt;
            r_out   <= w_out_nxt;
            r_en_o  <= w_en_o_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;
        w_sub_nxt   = r_sub;
        w_last_nxt  = r_last;
        w_out_nxt   = r_out;
        w_en_o_nxt  = r_en_o;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (en_i) begin
                    w_sub_nxt   = sub_i;
                    w_a_nxt     = {r_a[WIDTH-2:0], ina};
                    w_b_nxt     = {r_b[WIDTH-2:0], inb};
                    w_cnt_nxt   = CW'(WIDTH - 2);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_a_nxt = {r_a[WIDTH-2:0], ina};
                w_b_nxt = {r_b[WIDTH-2:0], inb};
                if (r_cnt == '0) w_state_nxt = CALC;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            CALC: begin
                w_res_nxt   = w_sum;
                w_out_nxt   = w_sum[WIDTH];
                w_en_o_nxt  = 1'b1;
                w_cnt_nxt   = CW'(WIDTH - 1);
                w_last_nxt  = 1'b0;
                w_state_nxt = SEND;
            end
            SEND: begin
                // r_last marks that result[0] is already on out; this edge closes the frame.
                if (r_last) begin
                    w_out_nxt   = 1'b0;
                    w_en_o_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_out_nxt = r_res[WIDTH-1];
                    w_res_nxt = {r_res[WIDTH-1:0], 1'b0};
                    if (r_cnt == '0) w_last_nxt = 1'b1;
                    else             w_cnt_nxt  = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out    = r_out;
    assign en_o   = r_en_o;
    assign busy_o = r_busy;
endmodule
